// File: rtl/pipelined_regfile.sv
// 32x32 register file with registered reads, same-edge write/clear bypass and a
// sequential clear engine that rejects writes while it runs.
module pipelined_regfile (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] WriteData,
   input  logic [4:0]  WriteRegister,
   input  logic        RegWrite,
   input  logic [4:0]  ReadRegister1,
   input  logic [4:0]  ReadRegister2,
   input  logic        ClearReq,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   output logic        Busy,
   output logic        WriteDropped
);

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 32;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic [DW-1:0]   rd1_q, rd1_d;
   logic [DW-1:0]   rd2_q, rd2_d;
   logic            wdrop_q, wdrop_d;
   logic            wr_acc;

   // Next state of storage and FSM; reads sample the next-state array so the
   // same-edge write and clear values are bypassed for free.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_d   = mem_q;
      wdrop_d = 1'b0;
      wr_acc  = RegWrite && (state_q == IDLE) && (WriteRegister != '0);

      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               mem_d[WriteRegister] = WriteData;
            end
            if (ClearReq) begin
               state_d = CLEAR;
               ptr_d   = AW'(1);
            end
         end
         CLEAR: begin
            wdrop_d      = RegWrite;
            mem_d[ptr_q] = '0;
            ptr_d        = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_d[0] = '0;
      rd1_d    = mem_d[ReadRegister1];
      rd2_d    = mem_d[ReadRegister2];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         wdrop_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         wdrop_q <= wdrop_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign ReadData1    = rd1_q;
   assign ReadData2    = rd2_q;
   assign WriteDropped = wdrop_q;
   assign Busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_pipelined_regfile.sv
// Directed bench for pipelined_regfile: vector table for single-cycle behaviour,
// hand sequences for the clear engine and mid-clear asynchronous reset.
module tb_pipelined_regfile;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] WriteData;
   logic [4:0]  WriteRegister;
   logic        RegWrite;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic        ClearReq;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        Busy;
   logic        WriteDropped;

   int checks = 0;
   int errors = 0;

   pipelined_regfile dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .WriteData     (WriteData),
      .WriteRegister (WriteRegister),
      .RegWrite      (RegWrite),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ClearReq      (ClearReq),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Busy          (Busy),
      .WriteDropped  (WriteDropped)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        ewd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, let one posedge pass, and return just after it.
   task automatic cycle(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic [4:0] rr1, input logic [4:0] rr2, input logic clr);
      RegWrite      = we;
      WriteRegister = wreg;
      WriteData     = wdata;
      ReadRegister1 = rr1;
      ReadRegister2 = rr2;
      ClearReq      = clr;
      @(posedge Clk);
      #1;
   endtask

   task automatic fill_index();
      for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
         chk({tag, "_rd1"}, ReadData1, 32'd0);
         chk({tag, "_rd2"}, ReadData2, 32'd0);
      end
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      logic        exp_wd;
      logic [31:0] exp1, exp2;

      vecs[0]  = '{1'b1, 5'd2,  32'd42,        5'd0,  5'd0,  32'd0,         32'd0,  1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'd0,         5'd2,  5'd2,  32'd42,        32'd42, 1'b0};
      vecs[2]  = '{1'b1, 5'd2,  32'd15,        5'd2,  5'd2,  32'd15,        32'd15, 1'b0};
      vecs[3]  = '{1'b0, 5'd2,  32'd30,        5'd2,  5'd2,  32'd15,        32'd15, 1'b0};
      vecs[4]  = '{1'b1, 5'd31, 32'd15,        5'd31, 5'd0,  32'd15,        32'd0,  1'b0};
      vecs[5]  = '{1'b1, 5'd16, 32'd31,        5'd16, 5'd31, 32'd31,        32'd15, 1'b0};
      vecs[6]  = '{1'b1, 5'd0,  32'd15,        5'd0,  5'd0,  32'd0,         32'd0,  1'b0};
      vecs[7]  = '{1'b1, 5'd5,  32'd15,        5'd5,  5'd0,  32'd15,        32'd0,  1'b0};
      vecs[8]  = '{1'b1, 5'd17, 32'd31,        5'd17, 5'd5,  32'd31,        32'd15, 1'b0};
      vecs[9]  = '{1'b1, 5'd7,  32'hDEADBEEF,  5'd7,  5'd2,  32'hDEADBEEF,  32'd15, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  32'd0,         5'd7,  5'd17, 32'hDEADBEEF,  32'd31, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd16, 32'd0,         32'd31, 1'b0};

      Reset = 1'b1;
      RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
      ReadRegister1 = '0; ReadRegister2 = '0; ClearReq = 1'b0;
      #2;
      chk("reset_rd1", ReadData1, 32'd0);
      chk("reset_rd2", ReadData2, 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_wd", 32'(WriteDropped), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      for (int v = 0; v < 12; v++) begin
         cycle(vecs[v].we, vecs[v].wreg, vecs[v].wdata, vecs[v].rr1, vecs[v].rr2, 1'b0);
         chk($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].e1);
         chk($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].e2);
         chk($sformatf("vec%0d_wd", v), 32'(WriteDropped), 32'(vecs[v].ewd));
         chk($sformatf("vec%0d_busy", v), 32'(Busy), 32'd0);
      end

      // Clear sequence with a simultaneous write on the start edge.
      fill_index();
      cycle(1'b1, 5'd3, 32'h333, 5'd3, 5'd3, 1'b1);
      chk("clr_start_busy", 32'(Busy), 32'd1);
      chk("clr_start_bypass", ReadData1, 32'h333);
      for (int e = 1; e <= 31; e++) begin
         cycle((e == 5) || (e == 7), (e == 5) ? 5'd4 : 5'd0, 32'h99, 5'd20, 5'd3, e == 10);
         exp_wd = (e == 5) || (e == 7);
         exp1   = (e >= 20) ? 32'd0 : 32'd20;
         exp2   = (e >= 3) ? 32'd0 : 32'h333;
         chk($sformatf("clr_e%0d_busy", e), 32'(Busy), (e < 31) ? 32'd1 : 32'd0);
         chk($sformatf("clr_e%0d_wd", e), 32'(WriteDropped), 32'(exp_wd));
         chk($sformatf("clr_e%0d_rd1", e), ReadData1, exp1);
         chk($sformatf("clr_e%0d_rd2", e), ReadData2, exp2);
      end
      cycle(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b0);
      chk("clr_done_busy", 32'(Busy), 32'd0);
      chk("clr_done_wd", 32'(WriteDropped), 32'd0);
      check_all_zero("clr_after");

      // Asynchronous reset in the middle of a clear.
      fill_index();
      cycle(1'b0, 5'd0, 32'd0, 5'd25, 5'd1, 1'b1);
      chk("rst_start_busy", 32'(Busy), 32'd1);
      chk("rst_start_rd1", ReadData1, 32'd25);
      chk("rst_start_rd2", ReadData2, 32'd1);
      for (int e = 1; e <= 10; e++) cycle(1'b0, 5'd0, 32'd0, 5'd25, 5'd0, 1'b0);
      chk("rst_pre_busy", 32'(Busy), 32'd1);
      chk("rst_pre_rd1", ReadData1, 32'd25);
      #3;
      Reset = 1'b1;
      #1;
      chk("rst_async_busy", 32'(Busy), 32'd0);
      chk("rst_async_rd1", ReadData1, 32'd0);
      chk("rst_async_rd2", ReadData2, 32'd0);
      chk("rst_async_wd", 32'(WriteDropped), 32'd0);
      RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'd5; ClearReq = 1'b1;
      ReadRegister1 = 5'd9;
      @(posedge Clk); @(posedge Clk); #1;
      chk("rst_hold_busy", 32'(Busy), 32'd0);
      chk("rst_hold_rd1", ReadData1, 32'd0);
      RegWrite = 1'b0; ClearReq = 1'b0;
      Reset = 1'b0;
      check_all_zero("rst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
